// File: rtl/exec_ctrl_pkg.sv
// Shared types and constants for the RV32 run-control sequencer.
package exec_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    ST_CORE_RST = 3'd0,
    ST_IDLE     = 3'd1,
    ST_RUN      = 3'd2,
    ST_STEP     = 3'd3,
    ST_HALTED   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OP_RUN   = 2'd0,
    OP_STEP  = 2'd1,
    OP_HALT  = 2'd2,
    OP_RESET = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    CAUSE_NONE    = 3'd0,
    CAUSE_HOST    = 3'd1,
    CAUSE_BREAK   = 3'd2,
    CAUSE_EBREAK  = 3'd3,
    CAUSE_ILLEGAL = 3'd4,
    CAUSE_LIMIT   = 3'd5,
    CAUSE_STEP    = 3'd6
  } halt_cause_e;

  localparam logic [XLEN-1:0] EBREAK_INSN  = 32'h0010_0073;
  localparam logic [XLEN-1:0] ILLEGAL_ZERO = 32'h0000_0000;
  localparam logic [XLEN-1:0] ILLEGAL_ONES = 32'hFFFF_FFFF;

  // One retired-instruction trace record.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } trace_rec_t;

  // Encodings that are never valid RV32 instructions (erased/blank memory).
  function automatic logic is_illegal(input logic [XLEN-1:0] insn);
    return (insn == ILLEGAL_ZERO) || (insn == ILLEGAL_ONES);
  endfunction

endpackage

// File: rtl/stop_detect.sv
// Combinational stop detector: illegal > EBREAK > PC breakpoint.
module stop_detect
  import exec_ctrl_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] instruction,
  input  logic            bp_en,
  input  logic [XLEN-1:0] bp_addr,
  input  logic            skip_bp,
  output logic            stop,
  output halt_cause_e     cause
);

  // Priority-ordered stop reason for the instruction about to execute.
  always_comb begin
    stop  = 1'b0;
    cause = CAUSE_NONE;
    if (is_illegal(instruction)) begin
      stop  = 1'b1;
      cause = CAUSE_ILLEGAL;
    end else if (instruction == EBREAK_INSN) begin
      stop  = 1'b1;
      cause = CAUSE_EBREAK;
    end else if (bp_en && (pc == bp_addr) && !skip_bp) begin
      stop  = 1'b1;
      cause = CAUSE_BREAK;
    end
  end

endmodule

// File: rtl/exec_controller.sv
// Run-control sequencer: gates core commit, sequences core reset, executes
// host RUN/STEP/HALT/RESET commands and emits a per-retire trace record.
module exec_controller
  import exec_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned RST_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  output logic             cmd_ready,
  output logic             cmd_err,
  input  logic             bp_en,
  input  logic [XLEN-1:0]  bp_addr,
  input  logic [CNT_W-1:0] run_limit,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  instruction,
  output logic             core_en,
  output logic             core_reset,
  output logic             halted,
  output logic [2:0]       halt_cause,
  output logic [CNT_W-1:0] retired,
  output logic             trace_valid,
  output logic [XLEN-1:0]  trace_pc,
  output logic [XLEN-1:0]  trace_instr
);

  localparam int unsigned   RST_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RST_CYCLES - 1);

  state_e           state_q, state_d;
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
  halt_cause_e      cause_q, cause_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic             skip_bp_q, skip_bp_d;
  logic             cmd_err_q, cmd_err_d;
  logic             trace_valid_q;
  trace_rec_t       trace_q;

  cmd_op_e          op;
  logic             cmd_acc_c;
  logic             reset_req_c;
  logic             halt_req_c;
  logic             limit_hit_c;
  logic             stop_c;
  halt_cause_e      stop_cause_c;

  assign op          = cmd_op_e'(cmd_op);
  assign cmd_acc_c   = cmd_valid && (state_q != ST_CORE_RST);
  assign reset_req_c = cmd_acc_c && (op == OP_RESET);
  assign halt_req_c  = cmd_acc_c && (op == OP_HALT);
  assign limit_hit_c = (run_limit != '0) && ((run_cnt_q + CNT_W'(1)) == run_limit);

  stop_detect u_stop_detect (
    .pc          (pc),
    .instruction (instruction),
    .bp_en       (bp_en),
    .bp_addr     (bp_addr),
    .skip_bp     (skip_bp_q),
    .stop        (stop_c),
    .cause       (stop_cause_c)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_CORE_RST;
    else        state_q <= state_d;
  end

  // Next state plus next values of the run-control registers.
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    cause_d   = cause_q;
    retired_d = retired_q;
    run_cnt_d = run_cnt_q;
    skip_bp_d = skip_bp_q;
    cmd_err_d = 1'b0;

    if (reset_req_c) begin
      state_d   = ST_CORE_RST;
      rst_cnt_d = RST_LOAD;
      cause_d   = CAUSE_NONE;
      retired_d = '0;
      run_cnt_d = '0;
    end else begin
      case (state_q)
        ST_CORE_RST: begin
          retired_d = '0;
          run_cnt_d = '0;
          if (rst_cnt_q == '0) state_d = ST_IDLE;
          else                 rst_cnt_d = rst_cnt_q - RST_W'(1);
        end
        ST_IDLE, ST_HALTED: begin
          if (cmd_acc_c) begin
            if (op == OP_RUN) begin
              state_d   = ST_RUN;
              run_cnt_d = '0;
              skip_bp_d = 1'b1;
              cause_d   = CAUSE_NONE;
            end else if (op == OP_STEP) begin
              state_d   = ST_STEP;
              skip_bp_d = 1'b1;
              cause_d   = CAUSE_NONE;
            end else begin
              cmd_err_d = 1'b1;
            end
          end
        end
        ST_RUN: begin
          cmd_err_d = cmd_acc_c && !halt_req_c;
          if (stop_c) begin
            state_d = ST_HALTED;
            cause_d = stop_cause_c;
          end else begin
            retired_d = retired_q + CNT_W'(1);
            run_cnt_d = run_cnt_q + CNT_W'(1);
            skip_bp_d = 1'b0;
            if (halt_req_c) begin
              state_d = ST_HALTED;
              cause_d = CAUSE_HOST;
            end else if (limit_hit_c) begin
              state_d = ST_HALTED;
              cause_d = CAUSE_LIMIT;
            end
          end
        end
        ST_STEP: begin
          cmd_err_d = cmd_acc_c;
          state_d   = ST_HALTED;
          if (stop_c) begin
            cause_d = stop_cause_c;
          end else begin
            retired_d = retired_q + CNT_W'(1);
            run_cnt_d = run_cnt_q + CNT_W'(1);
            skip_bp_d = 1'b0;
            cause_d   = CAUSE_STEP;
          end
        end
        default: begin
          state_d   = ST_CORE_RST;
          rst_cnt_d = RST_LOAD;
        end
      endcase
    end
  end

  // Outputs decoded from state; core_en also drops on stop or RESET command.
  always_comb begin
    cmd_ready  = (state_q != ST_CORE_RST);
    core_reset = (state_q == ST_CORE_RST);
    halted     = (state_q == ST_HALTED);
    core_en    = ((state_q == ST_RUN) || (state_q == ST_STEP)) && !stop_c && !reset_req_c;
  end

  // Run-control counters, status and trace registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_cnt_q     <= RST_LOAD;
      cause_q       <= CAUSE_NONE;
      retired_q     <= '0;
      run_cnt_q     <= '0;
      skip_bp_q     <= 1'b0;
      cmd_err_q     <= 1'b0;
      trace_valid_q <= 1'b0;
      trace_q       <= '0;
    end else begin
      rst_cnt_q     <= rst_cnt_d;
      cause_q       <= cause_d;
      retired_q     <= retired_d;
      run_cnt_q     <= run_cnt_d;
      skip_bp_q     <= skip_bp_d;
      cmd_err_q     <= cmd_err_d;
      trace_valid_q <= core_en;
      if (core_en) trace_q <= '{pc: pc, instr: instruction};
    end
  end

  assign cmd_err     = cmd_err_q;
  assign halt_cause  = cause_q;
  assign retired     = retired_q;
  assign trace_valid = trace_valid_q;
  assign trace_pc    = trace_q.pc;
  assign trace_instr = trace_q.instr;

endmodule

// File: tb/tb_exec_controller.sv
// Self-checking bench for exec_controller: directed scenarios plus random
// host commands, breakpoints and programs against a behavioural model.
module tb_exec_controller;

  localparam int CNT_W      = 32;
  localparam int RST_CYCLES = 2;
  localparam logic [31:0] NOP    = 32'h0050_0093;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  // Model modes (host-visible run status).
  localparam int M_RESET = 0, M_IDLE = 1, M_RUN = 2, M_STEP = 3, M_HALT = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic [1:0]       cmd_op;
  logic             cmd_ready;
  logic             cmd_err;
  logic             bp_en;
  logic [31:0]      bp_addr;
  logic [CNT_W-1:0] run_limit;
  logic [31:0]      pc;
  logic [31:0]      instruction;
  logic             core_en;
  logic             core_reset;
  logic             halted;
  logic [2:0]       halt_cause;
  logic [CNT_W-1:0] retired;
  logic             trace_valid;
  logic [31:0]      trace_pc;
  logic [31:0]      trace_instr;

  always #5 clk = ~clk;

  exec_controller #(.CNT_W(CNT_W), .RST_CYCLES(RST_CYCLES)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_op      (cmd_op),
    .cmd_ready   (cmd_ready),
    .cmd_err     (cmd_err),
    .bp_en       (bp_en),
    .bp_addr     (bp_addr),
    .run_limit   (run_limit),
    .pc          (pc),
    .instruction (instruction),
    .core_en     (core_en),
    .core_reset  (core_reset),
    .halted      (halted),
    .halt_cause  (halt_cause),
    .retired     (retired),
    .trace_valid (trace_valid),
    .trace_pc    (trace_pc),
    .trace_instr (trace_instr)
  );

  // Tiny core: 64-word program, PC advances by 4 on each commit.
  logic [31:0] mem [64];
  logic [31:0] core_pc;
  assign pc          = core_pc;
  assign instruction = mem[core_pc[7:2]];

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state.
  int          m_rst_left;
  int          m_mode;
  int          m_cause;
  logic [31:0] m_retired;
  logic [31:0] m_since;
  bit          m_resume;
  bit          m_tv;
  logic [31:0] m_tpc, m_tin;
  bit          m_err;
  bit          pend_en;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rst_left = RST_CYCLES;
    m_mode     = M_RESET;
    m_cause    = 0;
    m_retired  = 0;
    m_since    = 0;
    m_resume   = 0;
    m_tv       = 0;
    m_tpc      = 0;
    m_tin      = 0;
    m_err      = 0;
    pend_en    = 0;
  endtask

  // One clock: check outputs at the falling edge, advance the model, move the core.
  task automatic tick();
    bit   ready, acc, active, legal, en;
    int   op, reason;
    @(negedge clk);
    ready  = (m_rst_left == 0);
    acc    = cmd_valid && ready;
    op     = int'(cmd_op);
    active = (m_mode == M_RUN) || (m_mode == M_STEP);
    reason = 0;
    if (active) begin
      if (instruction == 32'h0 || instruction == 32'hFFFF_FFFF) reason = 4;
      else if (instruction == EBREAK)                           reason = 3;
      else if (bp_en && pc == bp_addr && !m_resume)             reason = 2;
    end
    en = active && (reason == 0) && !(acc && op == 3);

    check("core_en",    core_en,    en);
    check("core_reset", core_reset, m_rst_left > 0);
    check("cmd_ready",  cmd_ready,  ready);
    check("halted",     halted,     m_mode == M_HALT);
    check("halt_cause", halt_cause, m_cause);
    check("retired",    retired,    m_retired);
    check("cmd_err",    cmd_err,    m_err);
    check("trace_valid", trace_valid, m_tv);
    if (m_tv) begin
      check("trace_pc",    trace_pc,    m_tpc);
      check("trace_instr", trace_instr, m_tin);
    end

    legal = (op == 3) ||
            ((op == 0 || op == 1) && (m_mode == M_IDLE || m_mode == M_HALT)) ||
            (op == 2 && m_mode == M_RUN);
    m_err   = acc && !legal;
    m_tv    = en;
    pend_en = en;
    if (en) begin
      m_tpc = pc;
      m_tin = instruction;
    end

    if (m_rst_left > 0) begin
      m_rst_left--;
      m_retired = 0;
      m_since   = 0;
      if (m_rst_left == 0) m_mode = M_IDLE;
    end else if (acc && op == 3) begin
      m_rst_left = RST_CYCLES;
      m_mode     = M_RESET;
      m_cause    = 0;
      m_retired  = 0;
      m_since    = 0;
    end else if (active) begin
      if (en) begin
        m_retired++;
        m_since++;
        m_resume = 0;
      end
      if (reason != 0) begin
        m_mode = M_HALT; m_cause = reason;
      end else if (m_mode == M_STEP) begin
        m_mode = M_HALT; m_cause = 6;
      end else if (acc && op == 2) begin
        m_mode = M_HALT; m_cause = 1;
      end else if (run_limit != 0 && m_since == run_limit) begin
        m_mode = M_HALT; m_cause = 5;
      end
    end else if (acc && op == 0) begin
      m_mode = M_RUN; m_since = 0; m_resume = 1; m_cause = 0;
    end else if (acc && op == 1) begin
      m_mode = M_STEP; m_resume = 1; m_cause = 0;
    end

    @(posedge clk);
    #1;
    if (m_rst_left > 0)  core_pc = 32'h0;
    else if (pend_en)    core_pc = (core_pc + 32'd4) & 32'hFF;
    cmd_valid = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op);
    cmd_valid = 1'b1;
    cmd_op    = op;
    tick();
  endtask

  task automatic run_until_halt(input int budget);
    int n = 0;
    while (m_mode != M_HALT && n < budget) begin
      tick();
      n++;
    end
    check("halt_reached", halted, 1);
  endtask

  task automatic core_reset_cmd();
    issue(2'd3);
    tick();
    tick();
  endtask

  task automatic async_reset_check();
    reset = 1'b0;
    #1;
    check("ar_core_en",    core_en,     0);
    check("ar_core_reset", core_reset,  1);
    check("ar_cmd_ready",  cmd_ready,   0);
    check("ar_halted",     halted,      0);
    check("ar_cause",      halt_cause,  0);
    check("ar_retired",    retired,     0);
    check("ar_trace",      trace_valid, 0);
    check("ar_trace_pc",   trace_pc,    0);
    check("ar_cmd_err",    cmd_err,     0);
    @(posedge clk);
    #1;
    reset   = 1'b1;
    core_pc = 32'h0;
    model_reset();
  endtask

  function automatic logic [31:0] rand_insn();
    int r = $urandom_range(0, 39);
    if (r == 0) return 32'h0;
    if (r == 1) return 32'hFFFF_FFFF;
    if (r == 2) return EBREAK;
    return NOP ^ {$urandom_range(0, 255), 12'h0};
  endfunction

  initial begin
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    bp_en     = 1'b0;
    bp_addr   = 32'h0;
    run_limit = '0;
    core_pc   = 32'h0;
    for (int i = 0; i < 64; i++) mem[i] = NOP;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_core_reset", core_reset, 1);
    check("rst_core_en",    core_en,    0);
    check("rst_retired",    retired,    0);
    reset = 1'b1;
    tick();
    tick();
    check("rst_released", core_reset, 0);
    check("idle_ready",   cmd_ready,  1);

    // Single step from IDLE.
    issue(2'd1);
    tick();
    check("step_cause",   halt_cause,  6);
    check("step_retired", retired,     1);
    check("step_tv",      trace_valid, 1);
    check("step_tpc",     trace_pc,    0);
    check("step_tin",     trace_instr, NOP);

    // Run limit, twice.
    core_reset_cmd();
    run_limit = 5;
    issue(2'd0);
    run_until_halt(20);
    check("lim_cause",   halt_cause, 5);
    check("lim_retired", retired,    5);
    issue(2'd0);
    run_until_halt(20);
    check("lim2_retired", retired, 10);

    // Breakpoint at 0x10, then resume past it.
    core_reset_cmd();
    run_limit = 0;
    bp_en     = 1'b1;
    bp_addr   = 32'h10;
    issue(2'd0);
    run_until_halt(20);
    check("bp_cause",   halt_cause, 2);
    check("bp_retired", retired,    4);
    check("bp_pc",      pc,         32'h10);
    issue(2'd0);
    tick();
    check("bp_resume_retired", retired,  5);
    check("bp_resume_tpc",     trace_pc, 32'h10);
    tick();
    issue(2'd2);
    check("host_cause", halt_cause, 1);
    bp_en = 1'b0;

    // EBREAK then illegal at 0x8.
    core_reset_cmd();
    mem[2] = EBREAK;
    issue(2'd0);
    run_until_halt(20);
    check("ebreak_cause",   halt_cause, 3);
    check("ebreak_retired", retired,    2);
    mem[2] = 32'h0;
    issue(2'd0);
    run_until_halt(20);
    check("illegal_cause",   halt_cause, 4);
    check("illegal_retired", retired,    2);
    mem[2] = NOP;

    // HALT while idle is rejected.
    core_reset_cmd();
    issue(2'd2);
    check("halt_idle_err",    cmd_err, 1);
    check("halt_idle_halted", halted,  0);
    tick();
    check("halt_idle_err_clr", cmd_err, 0);

    // RESET command mid-RUN.
    issue(2'd0);
    repeat (3) tick();
    cmd_valid = 1'b1;
    cmd_op    = 2'd3;
    #1;
    check("rstcmd_core_en", core_en, 0);
    tick();
    check("rstcmd_core_reset", core_reset, 1);
    check("rstcmd_retired",    retired,    0);
    tick();
    tick();

    // Asynchronous reset mid-RUN.
    issue(2'd0);
    repeat (3) tick();
    check("pre_ar_core_en", core_en, 1);
    async_reset_check();

    // Randomized phase.
    for (int i = 0; i < 64; i++) mem[i] = rand_insn();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        cmd_valid = 1'b1;
        cmd_op    = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 19) == 0) bp_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) bp_addr = 32'($urandom_range(0, 63)) << 2;
      if ($urandom_range(0, 29) == 0) run_limit = CNT_W'($urandom_range(0, 10));
      if ($urandom_range(0, 49) == 0) mem[$urandom_range(0, 63)] = rand_insn();
      if ((m_mode == M_HALT || m_mode == M_IDLE) && $urandom_range(0, 7) == 0)
        core_pc = 32'($urandom_range(0, 63)) << 2;
      if ($urandom_range(0, 599) == 0) async_reset_check();
      else tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
